ldm_stm_sequencer: RTL and testbench

- Multi-cycle block-transfer master that drives the register file as its client. It issues one register read (A1/RD1) or one register write (A3/WD3/WE3) per cycle, with a matching data-memory access.
- Implements ARM LDM/STM in all four addressing modes (IA/IB/DA/DB), with optional base writeback.
- Sits beside the control unit. While Busy is high, the datapath stalls the PC and hands the register-file port and data-memory port to this block.

---
 rtl/ldm_stm_sequencer_pkg.sv | 13 +
 rtl/ldm_stm_sequencer_priority_enc16.sv | 13 +
 rtl/ldm_stm_sequencer.sv | 103 ++++++++++
 tb/tb_ldm_stm_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ldm_stm_sequencer_pkg.sv
// ldm_stm_sequencer_pkg: shared state, addressing-mode and register constants
package ldm_stm_sequencer_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XFER = 2'd1;
  localparam logic [1:0] S_WB   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;
  // addressing mode as {P,U}
  localparam logic [1:0] M_DA = 2'b00;
  localparam logic [1:0] M_IA = 2'b01;
  localparam logic [1:0] M_DB = 2'b10;
  localparam logic [1:0] M_IB = 2'b11;
  localparam logic [3:0] PC_IDX = 4'd15;
endpackage

// File: rtl/ldm_stm_sequencer_priority_enc16.sv
// priority_enc16: index of the lowest set bit of a 16-bit vector plus valid
module priority_enc16 (
  input  logic [15:0] in,
  output logic [3:0]  idx,
  output logic        valid
);
  always_comb begin
    idx = '0;
    for (int i = 15; i >= 0; i--)
      if (in[i]) idx = 4'(i);
    valid = |in;
  end
endmodule

// File: rtl/ldm_stm_sequencer.sv
// ldm_stm_sequencer: LDM/STM block-transfer master driving the register file and data memory
module ldm_stm_sequencer
  import ldm_stm_sequencer_pkg::*;
#(
  parameter int NREG = 16,
  parameter int AW   = 4
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            Start,
  input  logic            L,
  input  logic            P,
  input  logic            U,
  input  logic            W,
  input  logic [AW-1:0]   Rn,
  input  logic [NREG-1:0] RegList,
  input  logic [31:0]     BaseVal,
  output logic [AW-1:0]   A1,
  input  logic [31:0]     RD1,
  output logic [AW-1:0]   A3,
  output logic [31:0]     WD3,
  output logic            WE3,
  output logic            PCWrite,
  output logic [31:0]     PCData,
  output logic [31:0]     MemAddr,
  output logic            MemWrite,
  output logic [31:0]     WriteData,
  input  logic [31:0]     ReadData,
  output logic            Busy,
  output logic            Done
);
  logic [1:0]      st;
  logic            l, wb_en;
  logic [AW-1:0]   rn, r;
  logic [NREG-1:0] list, rest;
  logic [31:0]     addr, wbval, n4, start_addr;
  logic [4:0]      n;
  logic            rv, xfer, wb, ld, ld_pc, wb_rf, wb_pc;

  priority_enc16 u_enc (.in(list), .idx(r), .valid(rv));

  always_comb begin
    n = '0;
    for (int i = 0; i < NREG; i++) n = n + 5'(RegList[i]);
    n4 = {25'b0, n, 2'b0};
    start_addr = {P, U} == M_IA ? BaseVal :
                 {P, U} == M_IB ? BaseVal + 32'd4 :
                 {P, U} == M_DA ? BaseVal - n4 + 32'd4 : BaseVal - n4;
    rest = list & ~(NREG'(1) << r);
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      st    <= S_IDLE;
      l     <= 1'b0;
      wb_en <= 1'b0;
      rn    <= '0;
      list  <= '0;
      addr  <= '0;
      wbval <= '0;
    end else begin
      case (st)
        S_IDLE: if (Start) begin
          l     <= L;
          rn    <= Rn;
          list  <= RegList;
          addr  <= start_addr;
          wbval <= U ? BaseVal + n4 : BaseVal - n4;
          // a loaded base register wins over the writeback value
          wb_en <= W & ~(L & RegList[Rn]);
          st    <= n == 5'd0 ? S_DONE : S_XFER;
        end
        S_XFER: begin
          list <= rest;
          addr <= addr + 32'd4;
          if (rest == '0) st <= wb_en ? S_WB : S_DONE;
        end
        S_WB:    st <= S_DONE;
        default: st <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    xfer      = st == S_XFER && rv;
    wb        = st == S_WB;
    ld        = xfer && l && r != PC_IDX;
    ld_pc     = xfer && l && r == PC_IDX;
    wb_rf     = wb && rn != PC_IDX;
    wb_pc     = wb && rn == PC_IDX;
    A1        = xfer && !l ? r : '0;
    A3        = ld ? r : wb_rf ? rn : '0;
    WD3       = ld ? ReadData : wb_rf ? wbval : '0;
    WE3       = ld || wb_rf;
    PCWrite   = ld_pc || wb_pc;
    PCData    = ld_pc ? ReadData : wb_pc ? wbval : '0;
    MemAddr   = xfer ? addr : '0;
    MemWrite  = xfer && !l;
    WriteData = MemWrite ? RD1 : '0;
    Busy      = st != S_IDLE;
    Done      = st == S_DONE;
  end
endmodule

// File: tb/tb_ldm_stm_sequencer.sv
// tb_ldm_stm_sequencer: directed checks of the LDM/STM sequencer against hand-computed values
module tb_ldm_stm_sequencer;
  logic        CLK = 1'b0, RESET = 1'b1, Start = 1'b0;
  logic        L = 1'b0, P = 1'b0, U = 1'b0, W = 1'b0;
  logic [3:0]  Rn = '0, A1, A3;
  logic [15:0] RegList = '0;
  logic [31:0] BaseVal = '0, RD1, WD3, PCData, MemAddr, WriteData, ReadData;
  logic        WE3, PCWrite, MemWrite, Busy, Done;
  logic [31:0] rf [16];
  int          total = 0, bad = 0, mw_cnt = 0;

  ldm_stm_sequencer dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .L(L), .P(P), .U(U), .W(W),
    .Rn(Rn), .RegList(RegList), .BaseVal(BaseVal), .A1(A1), .RD1(RD1),
    .A3(A3), .WD3(WD3), .WE3(WE3), .PCWrite(PCWrite), .PCData(PCData),
    .MemAddr(MemAddr), .MemWrite(MemWrite), .WriteData(WriteData),
    .ReadData(ReadData), .Busy(Busy), .Done(Done)
  );

  always #5 CLK = ~CLK;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a == 32'h1F8 ? 32'hAA : a == 32'h1FC ? 32'hBB : a ^ 32'hA500_0000;
  endfunction

  assign RD1      = rf[A1];
  assign ReadData = memf(MemAddr);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  always @(posedge CLK) if (MemWrite) mw_cnt++;
  always @(negedge CLK) chk("onehot", 32'(WE3) + 32'(MemWrite) + 32'(PCWrite) <= 1, 1);

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic go(input logic l_, p_, u_, w_, input logic [3:0] rn_,
                    input logic [15:0] list_, input logic [31:0] base_);
    L = l_; P = p_; U = u_; W = w_; Rn = rn_; RegList = list_; BaseVal = base_;
    Start = 1'b1;
    cyc();
    Start = 1'b0;
  endtask

  task automatic st_chk(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_mw"}, 32'(MemWrite), 1);
    chk({tag, "_addr"}, MemAddr, a);
    chk({tag, "_wdata"}, WriteData, d);
  endtask

  task automatic ld_chk(input string tag, input logic [3:0] r, input logic [31:0] d);
    chk({tag, "_we3"}, 32'(WE3), 1);
    chk({tag, "_a3"}, 32'(A3), 32'(r));
    chk({tag, "_wd3"}, WD3, d);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rf[i] = 32'h1000 + 32'(i);
    rf[1] = 32'h11; rf[2] = 32'h22; rf[3] = 32'h33;
    #1;
    chk("rst_busy", 32'(Busy), 0);
    chk("rst_done", 32'(Done), 0);
    chk("rst_we3", 32'(WE3), 0);
    chk("rst_mw", 32'(MemWrite), 0);
    chk("rst_addr", MemAddr, 0);
    cyc(); cyc();
    RESET = 1'b0;
    cyc();

    // STM IA with writeback; a stray Start mid-transfer must be ignored
    go(0, 0, 1, 1, 4'd0, 16'h000E, 32'h100);
    chk("t1_busy", 32'(Busy), 1);
    st_chk("t1_c1", 32'h100, 32'h11);
    chk("t1_a1", 32'(A1), 1);
    L = 1'b1; RegList = 16'hFFFF; BaseVal = 32'h9999; Start = 1'b1;
    cyc();
    Start = 1'b0;
    st_chk("t1_c2", 32'h104, 32'h22);
    cyc();
    st_chk("t1_c3", 32'h108, 32'h33);
    cyc();
    ld_chk("t1_wb", 4'd0, 32'h10C);
    chk("t1_wb_mw", 32'(MemWrite), 0);
    cyc();
    chk("t1_done", 32'(Done), 1);
    chk("t1_busy5", 32'(Busy), 1);
    cyc();
    chk("t1_idle_busy", 32'(Busy), 0);
    chk("t1_idle_done", 32'(Done), 0);

    // LDM DB without writeback
    go(1, 1, 0, 0, 4'd6, 16'h0030, 32'h200);
    ld_chk("t2_c1", 4'd4, 32'hAA);
    chk("t2_addr1", MemAddr, 32'h1F8);
    cyc();
    ld_chk("t2_c2", 4'd5, 32'hBB);
    chk("t2_addr2", MemAddr, 32'h1FC);
    cyc();
    chk("t2_done", 32'(Done), 1);
    chk("t2_we3", 32'(WE3), 0);
    cyc();

    // LDM IA with base in list: loaded value wins, no writeback cycle
    go(1, 0, 1, 1, 4'd2, 16'h0006, 32'h40);
    ld_chk("t3_c1", 4'd1, 32'hA500_0040);
    cyc();
    ld_chk("t3_c2", 4'd2, 32'hA500_0044);
    cyc();
    chk("t3_done", 32'(Done), 1);
    chk("t3_we3", 32'(WE3), 0);
    cyc();

    // LDM IB with R15: PC load goes through PCWrite only
    go(1, 1, 1, 0, 4'd3, 16'h8001, 32'h0);
    ld_chk("t4_c1", 4'd0, 32'hA500_0004);
    chk("t4_addr1", MemAddr, 32'h4);
    cyc();
    chk("t4_pcw", 32'(PCWrite), 1);
    chk("t4_pcd", PCData, 32'hA500_0008);
    chk("t4_we3", 32'(WE3), 0);
    cyc();
    chk("t4_done", 32'(Done), 1);
    chk("t4_pcw_off", 32'(PCWrite), 0);
    cyc();

    // empty list: straight to DONE; Start during DONE ignored
    mw_cnt = 0;
    go(0, 0, 1, 1, 4'd0, 16'h0000, 32'h700);
    chk("t5_done", 32'(Done), 1);
    chk("t5_we3", 32'(WE3), 0);
    chk("t5_mw", 32'(MemWrite), 0);
    chk("t5_pcw", 32'(PCWrite), 0);
    RegList = 16'h0001; Start = 1'b1;
    cyc();
    Start = 1'b0;
    chk("t5_busy", 32'(Busy), 0);
    cyc();
    chk("t5_busy2", 32'(Busy), 0);
    chk("t5_mw_cnt", 32'(mw_cnt), 0);

    // reset during the 2nd XFER of a 4-register STM
    mw_cnt = 0;
    go(0, 0, 1, 0, 4'd9, 16'h000F, 32'h300);
    st_chk("t6_c1", 32'h300, 32'h1000);
    cyc();
    RESET = 1'b1;
    #1;
    chk("t6_mw", 32'(MemWrite), 0);
    chk("t6_busy", 32'(Busy), 0);
    chk("t6_addr", MemAddr, 0);
    chk("t6_a1", 32'(A1), 0);
    cyc(); cyc();
    chk("t6_mw_cnt", 32'(mw_cnt), 1);
    RESET = 1'b0;
    cyc();
    go(0, 0, 1, 0, 4'd9, 16'h0004, 32'h500);
    st_chk("t6_post", 32'h500, 32'h22);
    cyc();
    chk("t6_post_done", 32'(Done), 1);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
endmodule
